// File: rtl/coin_acceptor.sv
// coin_acceptor: turns the two raw, bouncy, active-low coin-chute switches
// (Rs5 and Rs10) into clean one-cycle denomination codes for the vending FSM.
// Stages: 2-flop synchronisers, per-channel debounce FSMs, simultaneous-coin
// serialisation via a one-entry pending slot, an accept/reject gate, and a
// chute-jam detector.
// Optional feature macro: COIN_COUNT_EN adds the saturating 16-bit coin_total
// register and port. Leaving the macro undefined gives the complete base
// design without that port.
module coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned JAM_CYCLES      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        coin5_n,
  input  logic        coin10_n,
  input  logic        accept_en,
  output logic [3:0]  denomination,
  output logic        coin_valid,
  output logic        coin_reject,
  output logic        jam
`ifdef COIN_COUNT_EN
  ,
  output logic [15:0] coin_total
`endif
);

  localparam int unsigned MAX_CYC = (DEBOUNCE_CYCLES > JAM_CYCLES) ? DEBOUNCE_CYCLES : JAM_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {
    REL       = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } deb_state_t;

  // Saturating increment shared by the debounce and jam counters.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CW'(MAX_CYC)) ? v : v + CW'(1);
  endfunction

  // Bit 0 is the Rs5 channel, bit 1 the Rs10 channel.
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    strobe;
  logic [1:0]    in_rel;
  logic [CW-1:0] jam_cnt;
  logic          both_low;
  logic          pending;
  logic          pending_next;
  logic          emit;
  logic          emit_ten;

  // Two-flop synchronisers; reset to the released (high) level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= {coin10_n, coin5_n};
      sync2 <= sync1;
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    deb_state_t    state;
    logic [CW-1:0] cnt;
    logic          s;

    assign s = sync2[ch];

    // Qualify strobe: the final required low sample while in PRESS_CHK.
    assign strobe[ch] = (state == PRESS_CHK) && !s && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign in_rel[ch] = (state == REL);

    // Debounce FSM: DEBOUNCE_CYCLES consecutive samples to accept a press or release.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state <= REL;
        cnt   <= '0;
      end else begin
        case (state)
          REL: begin
            if (!s) begin
              state <= PRESS_CHK;
              cnt   <= '0;
            end
          end
          PRESS_CHK: begin
            if (s) begin
              state <= REL;
              cnt   <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
              state <= HELD;
              cnt   <= '0;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
          HELD: begin
            if (s) begin
              state <= REL_CHK;
              cnt   <= '0;
            end
          end
          REL_CHK: begin
            if (!s) begin
              state <= HELD;
              cnt   <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
              state <= REL;
              cnt   <= '0;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
          default: begin
            state <= REL;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign both_low = !sync2[0] && !sync2[1];

  // Jam detector: set after JAM_CYCLES of both inputs low, cleared when both channels are released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      jam_cnt <= '0;
      jam     <= 1'b0;
    end else begin
      jam_cnt <= both_low ? sat_inc(jam_cnt) : '0;
      if (jam_cnt >= CW'(JAM_CYCLES)) begin
        jam <= 1'b1;
      end else if (in_rel == 2'b11) begin
        jam <= 1'b0;
      end
    end
  end

  // Emission select: Rs5 first, a coincident Rs10 waits one cycle in the pending slot.
  always_comb begin
    emit         = 1'b0;
    emit_ten     = 1'b0;
    pending_next = pending;
    if (strobe[0]) begin
      emit         = 1'b1;
      pending_next = pending | strobe[1];
    end else if (pending) begin
      emit         = 1'b1;
      emit_ten     = 1'b1;
      pending_next = strobe[1];
    end else if (strobe[1]) begin
      emit     = 1'b1;
      emit_ten = 1'b1;
    end
    if (jam) begin
      emit         = 1'b0;
      emit_ten     = 1'b0;
      pending_next = 1'b0;
    end
  end

  // Registered output stage; accept_en is sampled alongside each emission.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending      <= 1'b0;
      denomination <= 4'd0;
      coin_valid   <= 1'b0;
      coin_reject  <= 1'b0;
    end else begin
      pending      <= pending_next;
      denomination <= 4'd0;
      coin_valid   <= 1'b0;
      coin_reject  <= 1'b0;
      if (emit) begin
        if (accept_en) begin
          denomination <= emit_ten ? 4'd10 : 4'd5;
          coin_valid   <= 1'b1;
        end else begin
          coin_reject <= 1'b1;
        end
      end
    end
  end

`ifdef COIN_COUNT_EN
  logic [16:0] total_sum;

  assign total_sum = {1'b0, coin_total} + (emit_ten ? 17'd10 : 17'd5);

  // Running credited total, saturating at 65535.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coin_total <= 16'd0;
    end else if (emit && accept_en) begin
      coin_total <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: directed scenario tests for coin_acceptor with
// DEBOUNCE_CYCLES=4 and JAM_CYCLES=64. Inputs are driven on the falling edge,
// outputs sampled on the falling edge; cycle numbers are counted from the
// first falling edge after the stimulus change.
module tb_coin_acceptor;

  logic        clk = 1'b0;
  logic        rst;
  logic        coin5_n;
  logic        coin10_n;
  logic        accept_en;
  logic [3:0]  denomination;
  logic        coin_valid;
  logic        coin_reject;
  logic        jam;
  logic [15:0] coin_total;

  int checks = 0;
  int passed = 0;

  // Observation record, cycles relative to the last clear_obs
  int w_cyc, w_n5, w_n10, w_nrej, w_f5, w_l5, w_f10, w_frej, w_fjam, w_ljam, w_bad;

  coin_acceptor #(.DEBOUNCE_CYCLES(4), .JAM_CYCLES(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .coin5_n      (coin5_n),
    .coin10_n     (coin10_n),
    .accept_en    (accept_en),
    .denomination (denomination),
    .coin_valid   (coin_valid),
    .coin_reject  (coin_reject),
    .jam          (jam)
`ifdef COIN_COUNT_EN
    ,
    .coin_total   (coin_total)
`endif
  );

`ifndef COIN_COUNT_EN
  assign coin_total = 16'd0;
`endif

  always #5 clk = ~clk;

  task automatic clear_obs();
    w_cyc = 0; w_n5 = 0; w_n10 = 0; w_nrej = 0; w_bad = 0;
    w_f5 = -1; w_l5 = -1; w_f10 = -1; w_frej = -1; w_fjam = -1; w_ljam = -1;
  endtask

  // Step n cycles and record what the outputs did.
  task automatic observe(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      w_cyc++;
      if (coin_valid !== (denomination != 4'd0)) w_bad++;
      if (coin_valid && coin_reject) w_bad++;
      if (denomination == 4'd5) begin
        w_n5++;
        if (w_f5 < 0) w_f5 = w_cyc;
        w_l5 = w_cyc;
      end else if (denomination == 4'd10) begin
        w_n10++;
        if (w_f10 < 0) w_f10 = w_cyc;
      end else if (denomination != 4'd0) begin
        w_bad++;
      end
      if (coin_reject) begin
        w_nrej++;
        if (w_frej < 0) w_frej = w_cyc;
      end
      if (jam) begin
        if (w_fjam < 0) w_fjam = w_cyc;
        w_ljam = w_cyc;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; coin5_n = 1'b1; coin10_n = 1'b1; accept_en = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({denomination, coin_valid, coin_reject, jam} !== 7'd0) $display("FAIL reset_outputs: got %b expected 0", {denomination, coin_valid, coin_reject, jam});
    else passed++;
    checks++;
    if (coin_total !== 16'd0) $display("FAIL reset_total: got %0d expected 0", coin_total);
    else passed++;
    rst = 1'b1;
    clear_obs(); observe(10);
    checks++;
    if (w_n5 + w_n10 + w_nrej + w_bad !== 0 || w_fjam !== -1) $display("FAIL idle_quiet: got events %0d expected 0", w_n5 + w_n10 + w_nrej + w_bad);
    else passed++;
  endtask

  task automatic test_clean_press();
    coin5_n = 1'b0; clear_obs(); observe(20);
    coin5_n = 1'b1; observe(20);
    checks++;
    if (w_f5 !== 7) $display("FAIL clean_latency: got cycle %0d expected 7", w_f5);
    else passed++;
    checks++;
    if (w_n5 !== 1 || w_n10 !== 0 || w_nrej !== 0 || w_bad !== 0) $display("FAIL clean_count: got n5=%0d n10=%0d rej=%0d bad=%0d expected 1 0 0 0", w_n5, w_n10, w_nrej, w_bad);
    else passed++;
`ifdef COIN_COUNT_EN
    checks++;
    if (coin_total !== 16'd5) $display("FAIL clean_total: got %0d expected 5", coin_total);
    else passed++;
`endif
  endtask

  task automatic test_bounce();
    clear_obs();
    for (int i = 0; i < 6; i++) begin
      coin10_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      observe(2);
    end
    checks++;
    if (w_n10 !== 0 || w_n5 !== 0 || w_nrej !== 0) $display("FAIL bounce_filtered: got n10=%0d expected 0", w_n10);
    else passed++;
    coin10_n = 1'b0; clear_obs(); observe(20);
    coin10_n = 1'b1; observe(20);
    checks++;
    if (w_f10 !== 7) $display("FAIL bounce_latency: got cycle %0d expected 7", w_f10);
    else passed++;
    checks++;
    if (w_n10 !== 1 || w_n5 !== 0 || w_bad !== 0) $display("FAIL bounce_count: got n10=%0d n5=%0d bad=%0d expected 1 0 0", w_n10, w_n5, w_bad);
    else passed++;
`ifdef COIN_COUNT_EN
    checks++;
    if (coin_total !== 16'd15) $display("FAIL bounce_total: got %0d expected 15", coin_total);
    else passed++;
`endif
  endtask

  task automatic test_simultaneous();
    coin5_n = 1'b0; coin10_n = 1'b0; clear_obs(); observe(10);
    coin5_n = 1'b1; coin10_n = 1'b1; observe(20);
    checks++;
    if (w_f5 !== 7 || w_f10 !== 8) $display("FAIL simul_order: got c5=%0d c10=%0d expected 7 8", w_f5, w_f10);
    else passed++;
    checks++;
    if (w_n5 !== 1 || w_n10 !== 1 || w_bad !== 0 || w_fjam !== -1) $display("FAIL simul_count: got n5=%0d n10=%0d bad=%0d expected 1 1 0", w_n5, w_n10, w_bad);
    else passed++;
`ifdef COIN_COUNT_EN
    checks++;
    if (coin_total !== 16'd30) $display("FAIL simul_total: got %0d expected 30", coin_total);
    else passed++;
`endif
  endtask

  task automatic test_reject();
    accept_en = 1'b0; coin5_n = 1'b0; clear_obs(); observe(20);
    coin5_n = 1'b1; observe(20);
    accept_en = 1'b1;
    checks++;
    if (w_frej !== 7 || w_nrej !== 1) $display("FAIL reject_pulse: got cycle %0d count %0d expected 7 1", w_frej, w_nrej);
    else passed++;
    checks++;
    if (w_n5 !== 0 || w_n10 !== 0 || w_bad !== 0) $display("FAIL reject_nodenom: got n5=%0d bad=%0d expected 0 0", w_n5, w_bad);
    else passed++;
`ifdef COIN_COUNT_EN
    checks++;
    if (coin_total !== 16'd30) $display("FAIL reject_total: got %0d expected 30", coin_total);
    else passed++;
`endif
  endtask

  task automatic test_back_to_back();
    coin5_n = 1'b0; clear_obs(); observe(6);
    coin5_n = 1'b1; observe(6);
    coin5_n = 1'b0; observe(20);
    coin5_n = 1'b1; observe(20);
    checks++;
    if (w_n5 !== 2 || w_f5 !== 7 || w_l5 !== 19) $display("FAIL b2b_spacing: got n5=%0d first=%0d last=%0d expected 2 7 19", w_n5, w_f5, w_l5);
    else passed++;
`ifdef COIN_COUNT_EN
    checks++;
    if (coin_total !== 16'd40) $display("FAIL b2b_total: got %0d expected 40", coin_total);
    else passed++;
`endif
  endtask

  task automatic test_jam();
    coin5_n = 1'b0; coin10_n = 1'b0; clear_obs(); observe(80);
    checks++;
    if (w_f5 !== 7 || w_f10 !== 8 || w_n5 !== 1 || w_n10 !== 1) $display("FAIL jam_precoins: got c5=%0d c10=%0d n5=%0d n10=%0d expected 7 8 1 1", w_f5, w_f10, w_n5, w_n10);
    else passed++;
    checks++;
    if (w_fjam !== 67) $display("FAIL jam_rise: got cycle %0d expected 67", w_fjam);
    else passed++;
    coin5_n = 1'b1; clear_obs(); observe(20);
    coin5_n = 1'b0; observe(20);
    checks++;
    if (w_n5 !== 0 || w_n10 !== 0 || w_nrej !== 0) $display("FAIL jam_discard: got n5=%0d rej=%0d expected 0 0", w_n5, w_nrej);
    else passed++;
    checks++;
    if (jam !== 1'b1) $display("FAIL jam_held: got %0b expected 1", jam);
    else passed++;
    coin5_n = 1'b1; coin10_n = 1'b1; clear_obs(); observe(20);
    checks++;
    if (w_ljam !== 7 || jam !== 1'b0) $display("FAIL jam_clear: got last_jam_cycle=%0d jam=%0b expected 7 0", w_ljam, jam);
    else passed++;
`ifdef COIN_COUNT_EN
    checks++;
    if (coin_total !== 16'd55) $display("FAIL jam_total: got %0d expected 55", coin_total);
    else passed++;
`endif
  endtask

  task automatic test_reset_mid();
    coin5_n = 1'b0; clear_obs(); observe(5);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({denomination, coin_valid, coin_reject, jam} !== 7'd0 || coin_total !== 16'd0) $display("FAIL midrst_outputs: got %b total %0d expected 0", {denomination, coin_valid, coin_reject, jam}, coin_total);
    else passed++;
    @(negedge clk);
    rst = 1'b1; clear_obs(); observe(20);
    coin5_n = 1'b1; observe(20);
    checks++;
    if (w_f5 !== 7 || w_n5 !== 1 || w_nrej !== 0 || w_bad !== 0) $display("FAIL midrst_reemit: got cycle %0d n5=%0d expected 7 1", w_f5, w_n5);
    else passed++;
`ifdef COIN_COUNT_EN
    checks++;
    if (coin_total !== 16'd5) $display("FAIL midrst_total: got %0d expected 5", coin_total);
    else passed++;
`endif
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reject();
    test_back_to_back();
    test_jam();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
